// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with guard blanking and double-buffered data
//
// Scans NDIG hex digits onto one shared hex-to-segment decoder. Every digit slot
// is a BLANK guard of GUARD cycles (all anodes off, decoder input settling)
// followed by a SHOW window of DWELL cycles (one anode low). Display data is
// double-buffered: load captures into staging, and staging moves to the shadow
// (displayed) register only at the frame boundary.
//
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   load       in   one-cycle strobe, captures data_in into staging
//   data_in    in   [4*NDIG] digit nibbles, digit 0 in bits [3:0] (rightmost)
//   digit_en   in   [NDIG] per-digit enable, sampled on BLANK->SHOW
//   hex_out    out  [4] nibble to the hex-to-segment decoder
//   an         out  [NDIG] digit anodes, active-low
//   frame_done out  one-cycle pulse after the last digit's SHOW window
//   pending    out  staged data waiting for the frame boundary

module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int CNT_W = 16,
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*NDIG-1:0]   data_in,
  input  logic [NDIG-1:0]     digit_en,
  output logic [3:0]          hex_out,
  output logic [NDIG-1:0]     an,
  output logic                frame_done,
  output logic                pending
);

  localparam int IDX_W = $clog2(NDIG);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                en_q, en_d;
  logic [4*NDIG-1:0]   shadow_q, shadow_d;
  logic [4*NDIG-1:0]   staging_q, staging_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [3:0]          hex_q, hex_d;
  logic [NDIG-1:0]     an_q, an_d;

  logic guard_end, dwell_end, boundary, lzb_blank;

  assign guard_end = (state_q == ST_BLANK) && (cnt_q == CNT_W'(GUARD - 1));
  assign dwell_end = (state_q == ST_SHOW)  && (cnt_q == CNT_W'(DWELL - 1));
  assign boundary  = dwell_end && (idx_q == IDX_W'(NDIG - 1));

`ifdef SEG_SCAN_LZB_EN
  // Blank digit idx when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    lzb_blank = 1'b0;
    if (idx_q != '0) begin
      lzb_blank = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
        if ((k >= int'(idx_q)) && (shadow_q[4*k +: 4] != 4'h0)) lzb_blank = 1'b0;
      end
    end
  end
`else
  assign lzb_blank = 1'b0;
`endif

  // State register (all state and registered outputs)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      en_q         <= 1'b0;
      shadow_q     <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      hex_q        <= 4'h0;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      en_q         <= en_d;
      shadow_q     <= shadow_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      hex_q        <= hex_d;
      an_q         <= an_d;
    end
  end

  // Next-state logic: scan sequencing and the double buffer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    en_d      = en_q;
    shadow_d  = shadow_q;
    staging_d = staging_q;
    pending_d = pending_q;

    case (state_q)
      ST_BLANK: begin
        if (guard_end) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          en_d    = digit_en[idx_q] & ~lzb_blank;
        end
      end
      default: begin
        if (dwell_end) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
      end
    endcase

    if (load) staging_d = data_in;

    // A load landing on the boundary bypasses staging so it is not a frame late.
    if (boundary) begin
      if (load)           shadow_d = data_in;
      else if (pending_q) shadow_d = staging_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Output logic: computed from next state so the registered outputs align with the state
  always_comb begin
    frame_done_d = boundary;
    an_d         = '1;
    if ((state_d == ST_SHOW) && en_d) an_d[idx_d] = 1'b0;
    hex_d = hex_q;
    if (state_d == ST_BLANK) hex_d = shadow_d[4*idx_d +: 4];
  end

  assign hex_out    = hex_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int CNT_W = 16;
  localparam int GUARD = 1;
  localparam int DWELL = 4;
  localparam int SLOT  = GUARD + DWELL;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  digit_en;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_shadow, m_staging;
  logic        m_pend, m_fd;

  seg_scan_ctrl #(.NDIG(NDIG), .CNT_W(CNT_W), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .digit_en(digit_en),
    .hex_out(hex_out), .an(an), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lzb_mask(input logic [15:0] v);
    logic [3:0] m;
    m = 4'hF;
`ifdef SEG_SCAN_LZB_EN
    for (int d = NDIG - 1; d > 0; d--) begin
      if (v[4*d +: 4] != 4'h0) break;
      m[d] = 1'b0;
    end
`endif
    return m;
  endfunction

  // Checks ncyc cycles starting at frame cycle 0; optional single load at cycle load_at.
  task automatic run_frame(input int ncyc, input int load_at, input logic [15:0] load_val,
                           input logic [3:0] en_set);
    logic [3:0] en_eff, exp_an;
    int d, p;
    digit_en = en_set;
    en_eff   = en_set & lzb_mask(m_shadow);
    for (int c = 0; c < ncyc; c++) begin
      d = c / SLOT;
      p = c % SLOT;
      exp_an = 4'hF;
      if (p >= GUARD && en_eff[d]) exp_an[d] = 1'b0;
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL an cycle=%0d got=%b exp=%b", c, an, exp_an);
      end
      checks++;
      if (pending !== m_pend) begin
        errors++;
        $display("FAIL pending cycle=%0d got=%b exp=%b", c, pending, m_pend);
      end
      checks++;
      if (frame_done !== m_fd) begin
        errors++;
        $display("FAIL frame_done cycle=%0d got=%b exp=%b", c, frame_done, m_fd);
      end
      if (p >= GUARD) begin
        checks++;
        if (hex_out !== m_shadow[4*d +: 4]) begin
          errors++;
          $display("FAIL hex_out cycle=%0d got=%h exp=%h", c, hex_out, m_shadow[4*d +: 4]);
        end
      end
      if (c == load_at) begin
        load    = 1'b1;
        data_in = load_val;
      end
      tick();
      load = 1'b0;
      m_fd = (c == FRAME - 1);
      if (c == FRAME - 1) begin
        if (c == load_at) begin
          m_shadow  = load_val;
          m_staging = load_val;
        end else if (m_pend) begin
          m_shadow = m_staging;
        end
        m_pend = 1'b0;
      end else if (c == load_at) begin
        m_staging = load_val;
        m_pend    = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_shadow  = 16'h0;
    m_staging = 16'h0;
    m_pend    = 1'b0;
    m_fd      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++;
    if (hex_out !== 4'h0) begin errors++; $display("FAIL reset_hex got=%h exp=0", hex_out); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    tick();
    rst = 1'b0;
    model_reset();
    run_frame(FRAME, 0, 16'h1234, 4'hF);
  endtask

  task automatic test_scan_order();
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  task automatic test_tear_free();
    run_frame(FRAME, SLOT + 2, 16'hABCD, 4'hF);
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  task automatic test_boundary();
    run_frame(FRAME, FRAME - 1, 16'h5555, 4'hF);
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  task automatic test_digit_en();
    run_frame(FRAME, -1, 16'h0, 4'b0101);
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  task automatic test_async_reset();
    run_frame(2 * SLOT + GUARD + 2, -1, 16'h0, 4'hF);
    checks++;
    if (an !== 4'b1011) begin errors++; $display("FAIL pre_reset_an got=%b exp=1011", an); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL async_reset_an got=%b exp=1111", an); end
    checks++;
    if (hex_out !== 4'h0) begin errors++; $display("FAIL async_reset_hex got=%h exp=0", hex_out); end
    tick();
    rst = 1'b0;
    model_reset();
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  task automatic test_lzb();
    run_frame(FRAME, 0, 16'h0070, 4'hF);
    run_frame(FRAME, 0, 16'h0000, 4'hF);
    run_frame(FRAME, -1, 16'h0, 4'hF);
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    data_in  = 16'h0;
    digit_en = 4'hF;
    model_reset();
    test_reset();
    test_scan_order();
    test_tear_free();
    test_boundary();
    test_digit_en();
    test_async_reset();
    test_lzb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes NDIG hex digits onto one shared 4-bit-to-7-segment decoder and a common-cathode-bus display with active-low anodes.
- Sits between the application's display-data register and the hex-to-segment decoder. Drives the decoder input and the digit anodes.
- Inserts a blank guard interval between digits to prevent ghosting.
- Double-buffers display data so updates land only on frame boundaries, with no tearing.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- CNT_W, 16, width of the dwell/guard counter.
- DWELL, 50000, cycles each digit's anode is active (1..2^CNT_W-1).
- GUARD, 500, cycles all anodes are off before each digit (1..2^CNT_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; capture data_in into the staging register.
- data_in  input  4*NDIG  digit nibbles; digit k = data_in[4k+3:4k]; digit 0 is rightmost.
- digit_en  input  NDIG  per-digit enable; 0 keeps that anode off.
- hex_out  output  4  nibble to the hex-to-segment decoder.
- an  output  NDIG  anodes, active-low.
- frame_done  output  1  one-cycle pulse at the end of the last digit's SHOW.
- pending  output  1  staged data is waiting for the frame boundary.

Behaviour:
- Reset values (async assert, sync release):
  - an = all 1s, hex_out = 0, frame_done = 0, pending = 0.
  - shadow = 0, staging = 0, idx = 0, cnt = 0, state = BLANK.
- State machine has two states, BLANK and SHOW.
- BLANK:
  - an = all 1s.
  - hex_out = shadow nibble[idx], registered, so the decoder settles before the anode turns on.
  - cnt counts 0..GUARD-1; on cnt = GUARD-1, cnt <= 0, state <= SHOW, and digit_en[idx] is sampled into en_q.
- SHOW:
  - an[idx] = ~en_q; all other anodes = 1.
  - hex_out is unchanged.
  - cnt counts 0..DWELL-1; on cnt = DWELL-1, cnt <= 0, state <= BLANK, idx <= (idx+1) mod NDIG.
- Frame boundary = the SHOW exit cycle with idx = NDIG-1:
  - frame_done = 1 in the following cycle only.
  - If pending = 1: shadow <= staging, pending <= 0.
- Loading:
  - load = 1: staging <= data_in, pending <= 1.
  - A repeated load before the boundary overwrites staging (last value wins).
- Load coinciding with the boundary cycle: shadow <= data_in directly, staging <= data_in, pending stays 0.
- Frame period = NDIG*(GUARD+DWELL) cycles. Each anode is low for exactly DWELL consecutive cycles per frame, when enabled.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- digit_en changes mid-SHOW have no effect until the next BLANK->SHOW transition.
- Reset asserted mid-frame: all anodes go to 1 immediately (async). Scanning restarts from digit 0 in BLANK, and shadow data is lost (0).

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - At each BLANK->SHOW transition, en_q is additionally forced to 0 for digit idx if idx > 0 and shadow nibbles idx..NDIG-1 are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all enabled digits display, including leading zeros.
- Port list is identical in both builds.

Test Plan:
- Reset/scan order (NDIG=4, GUARD=1, DWELL=4; load 16'h1234, wait one frame):
  - an sequence is 1111, 1110 x4, 1111, 1101 x4, 1111, 1011 x4, 1111, 0111 x4.
  - hex_out is 4,3,2,1 during the respective SHOW windows.
  - frame_done pulses every 20 cycles.
- Tear-free update:
  - load 16'hABCD while idx = 1.
  - pending = 1 and display keeps 1234 for the rest of the frame.
  - From the next frame hex_out = D,C,B,A; pending returns to 0 at the boundary.
- Boundary collision: load 16'h5555 exactly on the boundary cycle -> next frame shows 5555, pending never goes high.
- digit_en = 4'b0101 -> an[1] and an[3] stay 1 all frame; digits 0 and 2 keep their full DWELL timing; frame period is still 20.
- Async reset mid-SHOW of digit 2 -> an = 1111 within the same cycle, no clock needed. After release, scan restarts at digit 0 showing 0.
- With SEG_SCAN_LZB_EN defined: load 16'h0070 -> anodes for digits 3 and 2 stay off; digits 1 and 0 show 7, 0. Load 16'h0000 -> only digit 0 is lit.
